// File: rtl/snn_input_loader_if.sv
// snn_input_loader_if
//   Bundles the byte stream from the UART receiver and the pixel read port /
//   start-done handshake toward snn_core into a single connection.
//
//   Signals
//     rx_data          8   byte from the UART receiver
//     rx_rdy           1   one-cycle pulse, rx_data valid in that cycle
//     addr_input_unit  10  pixel read address from snn_core (0..783)
//     q_input          1   pixel at the address registered on the previous edge
//     start            1   one-cycle pulse to snn_core, image ready
//     core_done        1   one-cycle pulse from snn_core, classification finished
//
//   Modports
//     master  the environment side (UART receiver + snn_core)
//     slave   the loader itself
interface snn_input_loader_if;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic [9:0] addr_input_unit;
  logic       q_input;
  logic       start;
  logic       core_done;

  modport master (
    output rx_data,
    output rx_rdy,
    output addr_input_unit,
    output core_done,
    input  q_input,
    input  start
  );

  modport slave (
    input  rx_data,
    input  rx_rdy,
    input  addr_input_unit,
    input  core_done,
    output q_input,
    output start
  );
endinterface

// File: rtl/snn_input_loader.sv
// snn_input_loader
//   Collects one 28x28 binarized image as NUM_BYTES packed bytes (pixel 8k+j is
//   bit j of byte k), stores it in a pixel buffer, serves that buffer to
//   snn_core through a 1-cycle-latency read port, pulses start once the image
//   is complete and then refuses new bytes until snn_core reports done.
//   A partial image that sits idle for TIMEOUT_CYC cycles is discarded so the
//   byte counter resynchronises to a fresh image.
//
//   Ports
//     clk          system clock
//     rst_n        synchronous active-low reset (buffer contents are kept)
//     bus          snn_input_loader_if.slave: rx_data/rx_rdy in,
//                  addr_input_unit/core_done in, q_input/start out
//     busy         high while an image is handed to snn_core (START or RUN)
//     byte_cnt     bytes of the current image received so far
//     drop_err     sticky, a byte arrived while busy
//     timeout_err  sticky, a partial image was discarded by the timeout
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_LOAD  | accepting bytes into the buffer, timeout armed on partials
//   S_START | image complete, start pulse to snn_core for this one cycle
//   S_RUN   | snn_core classifying; bytes dropped, wait for core_done
module snn_input_loader #(
  parameter int NUM_BYTES   = 98,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                clk,
  input  logic                rst_n,
  snn_input_loader_if.slave   bus,
  output logic                busy,
  output logic [6:0]          byte_cnt,
  output logic                drop_err,
  output logic                timeout_err
);

  localparam int             TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0]  TMO_MAX  = TW'(TIMEOUT_CYC - 1);
  localparam logic [6:0]     LAST_IDX = 7'(NUM_BYTES - 1);
  localparam logic [9:0]     PIX_END  = 10'(NUM_BYTES * 8);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Idle time is tracked as cycles remaining before the partial image is
  // dropped; a full reload corresponds to an idle count of zero.
  logic [TW-1:0] tmo_left;

  logic [7:0] pix_mem [NUM_BYTES];

  logic rx_accept;
  logic last_byte;
  logic tmo_fire;

  assign rx_accept = (state == S_LOAD) && bus.rx_rdy;
  assign last_byte = (byte_cnt == LAST_IDX);
  // rx_rdy in the would-be firing cycle wins: the byte is taken instead.
  assign tmo_fire  = (state == S_LOAD) && !bus.rx_rdy &&
                     (byte_cnt != 7'd0) && (tmo_left == '0);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD: begin
        if (bus.rx_rdy && last_byte) begin
          state_nxt = S_START;
        end
      end
      S_START: begin
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (bus.core_done) begin
          state_nxt = S_LOAD;
        end
      end
      default: begin
        state_nxt = S_LOAD;
      end
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    busy      = 1'b0;
    bus.start = 1'b0;
    case (state)
      S_START: begin
        busy      = 1'b1;
        bus.start = 1'b1;
      end
      S_RUN: begin
        busy = 1'b1;
      end
      default: begin
        busy      = 1'b0;
        bus.start = 1'b0;
      end
    endcase
  end

  // Byte counter, idle timer and sticky flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt    <= 7'd0;
      tmo_left    <= TMO_MAX;
      drop_err    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (bus.rx_rdy) begin
            tmo_left <= TMO_MAX;
            if (last_byte) begin
              // Flags describe the image being handed over, so they are
              // cleared as the START cycle begins.
              byte_cnt    <= 7'd0;
              drop_err    <= 1'b0;
              timeout_err <= 1'b0;
            end else begin
              byte_cnt <= byte_cnt + 7'd1;
            end
          end else if (tmo_fire) begin
            byte_cnt    <= 7'd0;
            tmo_left    <= TMO_MAX;
            timeout_err <= 1'b1;
          end else if (byte_cnt != 7'd0) begin
            tmo_left <= tmo_left - TW'(1);
          end
        end
        S_START, S_RUN: begin
          if (bus.rx_rdy) begin
            drop_err <= 1'b1;
          end
        end
        default: begin
          byte_cnt <= 7'd0;
        end
      endcase
    end
  end

  // Pixel buffer write port; not cleared by reset.
  always_ff @(posedge clk) begin
    if (rst_n && rx_accept) begin
      pix_mem[byte_cnt] <= bus.rx_data;
    end
  end

  // Pixel read port: registered, so a same-cycle write to the word returns
  // the old contents. Addresses past the image read as 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.q_input <= 1'b0;
    end else if (bus.addr_input_unit < PIX_END) begin
      bus.q_input <= pix_mem[bus.addr_input_unit[9:3]][bus.addr_input_unit[2:0]];
    end else begin
      bus.q_input <= 1'b0;
    end
  end

endmodule

// File: tb/tb_snn_input_loader.sv
module tb_snn_input_loader;
  localparam int NB  = 98;
  localparam int TMO = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snn_input_loader_if bus();
  logic       busy;
  logic [6:0] byte_cnt;
  logic       drop_err;
  logic       timeout_err;

  snn_input_loader #(.NUM_BYTES(NB), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave),
    .busy(busy),
    .byte_cnt(byte_cnt),
    .drop_err(drop_err),
    .timeout_err(timeout_err)
  );

  int total = 0;
  int bad = 0;
  int start_seen = 0;

  // Reference model: image buffer as a byte array, partial image as a count
  // of bytes received, idle time counted upward.
  int m_phase;      // 0 = loading, 1 = start cycle, 2 = core running
  int m_cnt;
  int m_idle;
  int m_drop;
  int m_terr;
  int m_q;
  bit m_qv;
  int m_mem [NB];
  bit m_wr  [NB];

  typedef struct {
    logic [9:0] addr;
    logic       exp_q;
  } rd_vec_t;
  rd_vec_t tbl [8];

  function automatic void check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_clock();
    int a;
    int w;
    if (!rst_n) begin
      m_phase = 0; m_cnt = 0; m_idle = 0; m_drop = 0; m_terr = 0;
      m_q = 0; m_qv = 1'b1;
      return;
    end
    a = int'(bus.addr_input_unit);
    if (a >= NB * 8) begin
      m_q = 0; m_qv = 1'b1;
    end else begin
      w = a / 8;
      m_q = (m_mem[w] >> (a % 8)) & 1;
      m_qv = m_wr[w];
    end
    case (m_phase)
      0: begin
        if (bus.rx_rdy) begin
          m_mem[m_cnt] = int'(bus.rx_data);
          m_wr[m_cnt] = 1'b1;
          m_idle = 0;
          m_cnt++;
          if (m_cnt == NB) begin
            m_cnt = 0; m_phase = 1; m_drop = 0; m_terr = 0;
          end
        end else if (m_cnt > 0) begin
          m_idle++;
          if (m_idle == TMO) begin
            m_cnt = 0; m_idle = 0; m_terr = 1;
          end
        end
      end
      1: begin
        m_phase = 2;
        if (bus.rx_rdy) m_drop = 1;
      end
      default: begin
        if (bus.rx_rdy) m_drop = 1;
        if (bus.core_done) m_phase = 0;
      end
    endcase
  endfunction

  function automatic void check_model();
    check("cycle_start", int'(bus.start), (m_phase == 1) ? 1 : 0);
    check("cycle_busy", int'(busy), (m_phase != 0) ? 1 : 0);
    check("cycle_byte_cnt", int'(byte_cnt), m_cnt);
    check("cycle_drop_err", int'(drop_err), m_drop);
    check("cycle_timeout_err", int'(timeout_err), m_terr);
    if (m_qv) check("cycle_q_input", int'(bus.q_input), m_q);
  endfunction

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    if (bus.start) start_seen++;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic send(input logic [7:0] d);
    bus.rx_data = d;
    bus.rx_rdy = 1'b1;
    step();
    bus.rx_rdy = 1'b0;
  endtask

  function automatic logic [7:0] byte_of(input int kind, input int i);
    case (kind)
      0: return 8'hA5;
      1: return 8'(i);
      default: return 8'(i * 37 + 11);
    endcase
  endfunction

  // Sends a full image from LOAD; checks the start pulse lands right after
  // the last byte and occurs exactly once.
  task automatic send_image(input int kind, input int gap);
    int s0;
    s0 = start_seen;
    for (int i = 0; i < NB; i++) begin
      send(byte_of(kind, i));
      if (i == NB - 1) begin
        check("start_after_last_byte", int'(bus.start), 1);
        check("busy_with_start", int'(busy), 1);
      end else if (i != NB - 2) begin
        check("no_early_start", int'(bus.start), 0);
      end
      if (i != NB - 1) idle(gap - 1);
    end
    idle(2);
    check("start_pulse_count", start_seen - s0, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst_byte_cnt", int'(byte_cnt), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_start", int'(bus.start), 0);
    check("rst_drop_err", int'(drop_err), 0);
    check("rst_timeout_err", int'(timeout_err), 0);
    check("rst_q_input", int'(bus.q_input), 0);
  endtask

  task automatic read_q(input logic [9:0] a, input int exp, input string name);
    bus.addr_input_unit = a;
    step();
    check(name, int'(bus.q_input), exp);
  endtask

  task automatic pulse_done();
    bus.core_done = 1'b1;
    step();
    bus.core_done = 1'b0;
  endtask

  initial begin
    int mode;
    bus.rx_data = 8'h00;
    bus.rx_rdy = 1'b0;
    bus.addr_input_unit = 10'd0;
    bus.core_done = 1'b0;
    for (int i = 0; i < NB; i++) begin
      m_mem[i] = 0;
      m_wr[i] = 1'b0;
    end
    tbl[0] = '{10'd0,    1'b1};
    tbl[1] = '{10'd1,    1'b0};
    tbl[2] = '{10'd2,    1'b1};
    tbl[3] = '{10'd5,    1'b1};
    tbl[4] = '{10'd6,    1'b0};
    tbl[5] = '{10'd7,    1'b1};
    tbl[6] = '{10'd784,  1'b0};
    tbl[7] = '{10'd1023, 1'b0};

    step();
    do_reset();
    idle(3);

    // A5 image, bytes 20 cycles apart, then table reads
    send_image(0, 20);
    check("busy_in_run", int'(busy), 1);
    for (int i = 0; i < 8; i++) read_q(tbl[i].addr, int'(tbl[i].exp_q), "a5_table_read");

    // Bytes while busy are dropped and leave the buffer alone
    for (int i = 0; i < 3; i++) begin
      send(8'h00);
      idle(2);
    end
    check("drop_err_while_busy", int'(drop_err), 1);
    read_q(10'd0, 1, "buffer_kept_after_drop0");
    read_q(10'd2, 1, "buffer_kept_after_drop2");
    pulse_done();
    check("busy_low_after_done", int'(busy), 0);
    check("drop_err_sticky_in_load", int'(drop_err), 1);

    // Index image back-to-back, then full sweep
    send_image(1, 1);
    check("drop_err_cleared_by_start", int'(drop_err), 0);
    for (int a = 0; a < NB * 8; a++)
      read_q(10'(a), ((a / 8) >> (a % 8)) & 1, "index_sweep");
    read_q(10'd784, 0, "addr_784_zero");

    // rx_rdy together with core_done in RUN
    bus.rx_data = 8'hFF;
    bus.rx_rdy = 1'b1;
    bus.core_done = 1'b1;
    step();
    bus.rx_rdy = 1'b0;
    bus.core_done = 1'b0;
    check("coinc_drop_err", int'(drop_err), 1);
    check("coinc_busy", int'(busy), 0);
    check("coinc_byte_cnt", int'(byte_cnt), 0);
    read_q(10'd0, 0, "coinc_buffer_kept");

    // rx_rdy in the START cycle
    for (int i = 0; i < NB; i++) send(byte_of(2, i));
    check("start_seen_before_inject", int'(bus.start), 1);
    bus.rx_data = 8'h00;
    bus.rx_rdy = 1'b1;
    step();
    bus.rx_rdy = 1'b0;
    check("start_cycle_drop_err", int'(drop_err), 1);
    check("start_cycle_busy", int'(busy), 1);
    check("start_single_cycle", int'(bus.start), 0);
    read_q(10'd0, 1, "start_cycle_buffer0");
    read_q(10'd2, 0, "start_cycle_buffer2");
    pulse_done();

    // Timeout discards a 40-byte partial image
    for (int i = 0; i < 40; i++) send(byte_of(2, i));
    idle(98);
    check("partial_kept_before_timeout", int'(byte_cnt), 40);
    check("no_timeout_yet", int'(timeout_err), 0);
    idle(2);
    check("timeout_byte_cnt", int'(byte_cnt), 0);
    check("timeout_err_set", int'(timeout_err), 1);
    send_image(1, 1);
    read_q(10'd0, 0, "new_image_word0");
    read_q(10'd312, 1, "new_image_word39");
    check("timeout_err_cleared", int'(timeout_err), 0);
    pulse_done();

    // rx_rdy lands in the cycle the timeout would fire
    send(8'h55);
    idle(TMO - 1);
    send(8'h66);
    check("tmo_race_byte_cnt", int'(byte_cnt), 2);
    check("tmo_race_timeout_err", int'(timeout_err), 0);
    idle(TMO);
    check("tmo_after_race", int'(timeout_err), 1);

    // Reset mid-load and mid-run
    for (int i = 0; i < 50; i++) send(8'(i));
    do_reset();
    send_image(0, 1);
    send(8'h00);
    do_reset();
    send_image(1, 2);
    pulse_done();

    // Randomized traffic against the model
    mode = 0;
    for (int c = 0; c < 4000; c++) begin
      if ((c % 150) == 0) mode = int'($urandom_range(0, 2));
      rst_n = ($urandom_range(0, 999) != 0);
      case (mode)
        0: bus.rx_rdy = ($urandom_range(0, 1) == 1);
        1: bus.rx_rdy = ($urandom_range(0, 59) == 0);
        default: bus.rx_rdy = ($urandom_range(0, 399) == 0);
      endcase
      bus.rx_data = 8'($urandom);
      bus.core_done = ($urandom_range(0, 29) == 0);
      bus.addr_input_unit = 10'($urandom_range(0, 1023));
      step();
    end
    rst_n = 1'b1;
    bus.rx_rdy = 1'b0;
    bus.core_done = 1'b0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
